// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with parallel load, wrap/saturate ends, and terminal-count flag.
// Optional wrap-event tally enabled by defining MODN_COUNTER_WRAPCNT_EN; otherwise wrap_cnt reads 0.
module modn_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 12,
    parameter int SATURATE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err,
    output logic [7:0]       wrap_cnt
);

    generate
        if (WIDTH < 1 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_params
            $error("modn_updown_counter: need WIDTH >= 1 and 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_load_err;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_din_oob;
    logic             w_at_end;
    logic             w_step_wrap;

    assign w_at_max  = (r_count == MAX_VAL);
    assign w_at_zero = (r_count == '0);
    // Extra bit lets MODULUS == 2**WIDTH compare correctly.
    assign w_din_oob = ({1'b0, din} >= (WIDTH + 1)'(MODULUS));
    assign w_at_end  = up_down ? w_at_max : w_at_zero;
    assign w_step_wrap = !load && enable && w_at_end && (SATURATE == 0);

    assign tc       = w_at_end;
    assign count    = r_count;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= w_step_wrap;
            r_load_err <= load && w_din_oob;
            if (load) begin
                r_count <= w_din_oob ? MAX_VAL : din;
            end else if (enable) begin
                if (up_down) begin
                    if (!w_at_max) begin
                        r_count <= r_count + WIDTH'(1);
                    end else if (SATURATE == 0) begin
                        r_count <= '0;
                    end
                end else begin
                    if (!w_at_zero) begin
                        r_count <= r_count - WIDTH'(1);
                    end else if (SATURATE == 0) begin
                        r_count <= MAX_VAL;
                    end
                end
            end
        end
    end

`ifdef MODN_COUNTER_WRAPCNT_EN
    logic [7:0] r_wrap_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wrap_cnt <= 8'd0;
        end else if (w_step_wrap) begin
            r_wrap_cnt <= r_wrap_cnt + 8'd1;
        end
    end

    assign wrap_cnt = r_wrap_cnt;
`else
    assign wrap_cnt = 8'd0;
`endif

endmodule

// File: doc/modn_updown_counter.md
MODN_UPDOWN_COUNTER -- requirements
Module: modn_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: count and din width in bits.
REQ-002 SHALL have parameter MODULUS, default 12: count range is 0..MODULUS-1.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at the range ends, 1 = hold at the range ends.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1 bit: count-step qualifier.
REQ-007 SHALL have port load, input, 1 bit: synchronous parallel-load request.
REQ-008 SHALL have port din, input, WIDTH bits: load value.
REQ-009 SHALL have port up_down, input, 1 bit: 1 = count up, 0 = count down.
REQ-010 SHALL have port count, output, WIDTH bits: registered counter value.
REQ-011 SHALL have port tc, output, 1 bit: combinational terminal-count flag.
REQ-012 SHALL have port wrap, output, 1 bit: registered wrap-event pulse.
REQ-013 SHALL have port load_err, output, 1 bit: registered out-of-range-load pulse.
REQ-014 SHALL have port wrap_cnt, output, 8 bits: wrap-event tally.

Function
REQ-015 SHALL fail elaboration unless 2 <= MODULUS <= 2**WIDTH and WIDTH >= 1.
REQ-016 SHALL apply per-edge priority: load, then enable-qualified step, then hold.
REQ-017 SHALL, on load with din < MODULUS, set count to din at that edge, regardless of enable and up_down.
REQ-018 SHALL, on load with din >= MODULUS, set count to MODULUS-1 and pulse load_err high for exactly one cycle after that edge.
REQ-019 SHALL, with enable=1, load=0, up_down=1 and count < MODULUS-1, increment count by 1.
REQ-020 SHALL, with enable=1, load=0, up_down=0 and count > 0, decrement count by 1.
REQ-021 SHALL, with SATURATE=0 and an up-step at MODULUS-1, set count to 0; with a down-step at 0, set count to MODULUS-1; both pulse wrap for one cycle after the edge.
REQ-022 SHALL, with SATURATE=1, hold count at an end-of-range step and never assert wrap.
REQ-023 SHALL drive tc = (up_down and count==MODULUS-1) or (not up_down and count==0), independent of enable and load.
REQ-024 SHALL hold count and clear wrap and load_err at the next edge when enable=0 and load=0.
REQ-025 SHALL perform all step arithmetic modulo MODULUS, never modulo 2**WIDTH; count SHALL never leave 0..MODULUS-1.
REQ-026 SHALL NOT assert wrap on a load, including a load that takes the place of a wrapping step.

Reset
REQ-027 SHALL, on reset assertion, immediately set count=0, wrap=0, load_err=0, wrap_cnt=0, with no clock edge required.
REQ-028 SHALL ignore load and enable while reset is high; counting resumes at the first rising edge after deassertion.
REQ-029 SHALL abort any in-progress load or wrap when reset asserts mid-operation, leaving no pending pulse.

Configuration
REQ-030 SHALL, with macro MODN_COUNTER_WRAPCNT_EN defined, increment wrap_cnt by 1 at every edge that asserts wrap, wrapping from 255 to 0, and clear it only by reset.
REQ-031 SHALL, without MODN_COUNTER_WRAPCNT_EN, tie wrap_cnt to 0 and contain no wrap-tally logic.

Verification (WIDTH=4, MODULUS=12 unless stated)
REQ-032 SHALL pulse reset mid-count at count=7 between edges -> count=0, all flags 0 immediately.
REQ-033 SHALL load din=5, then 7 enabled up-steps -> count 6..11, then 0 with one wrap pulse; wrap_cnt=1 if MODN_COUNTER_WRAPCNT_EN is defined.
REQ-034 SHALL load din=15 -> count=11, load_err high for exactly one cycle.
REQ-035 SHALL from count=0, up_down=0, one enabled edge -> count=11, wrap pulse; tc=1 before the edge.
REQ-036 SHALL with load=1, enable=1, up_down=1 and din=3 at the same edge -> count=3, wrap=0.
REQ-037 SHALL with SATURATE=1 at count=11, up_down=1, 3 enabled edges -> count stays 11, wrap never 1.
